ecc_write_encoder: RTL and testbench

ECC_WRITE_ENCODER -- requirements
Module: ecc_write_encoder

---
 rtl/ecc_write_encoder.sv | 98 +++++++++
 tb/tb_ecc_write_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_write_encoder.sv
// ecc_write_encoder: SECDED Hamming(38,32)+parity encoder with optional input register,
// valid/ready handshake on both sides, one-shot error injection and a write counter.
module ecc_write_encoder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cfg_set_inputreg_i,
   input  logic              cfg_ecc_enable_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              inject_arm_i,
   input  logic [1:0]        inject_mode_i,
   output logic              ram_valid_o,
   input  logic              ram_ready_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [39:0]       ram_wrdata_o,
   output logic [15:0]       wr_count_o
);
   logic              s1_v_q, s2_v_q, armed_q;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] s1_addr_q, s2_addr_q, s2_in_addr;
   logic [31:0]       s1_data_q, s2_in_data, flip;
   logic [39:0]       s2_word_q, word_d;
   logic [15:0]       cnt_q;
   logic              s2_rdy, s1_ld, s2_in_v, s2_ld, arm_eff, p;
   logic [1:0]        mode_eff;
   logic [5:0]        c;

   // Walk data bits through codeword positions 3,5,6,7,9,... skipping powers of two.
   function automatic logic [5:0] check_bits(input logic [31:0] d);
      logic [5:0] cb;
      logic [5:0] pos;
      cb = '0;
      pos = 6'd3;
      for (int i = 0; i < 32; i++) begin
         for (int k = 0; k < 6; k++)
            if (pos[k]) cb[k] = cb[k] ^ d[i];
         pos = pos + 6'd1;
         if ((pos & (pos - 6'd1)) == 6'd0) pos = pos + 6'd1;
      end
      return cb;
   endfunction

   assign s2_rdy     = !s2_v_q | ram_ready_i;
   assign wr_ready_o = rst_n_i & (cfg_set_inputreg_i ? (!s1_v_q | s2_rdy) : s2_rdy);
   assign s1_ld      = cfg_set_inputreg_i & wr_valid_i & wr_ready_o;
   assign s2_in_v    = cfg_set_inputreg_i ? s1_v_q : wr_valid_i;
   assign s2_ld      = s2_in_v & s2_rdy;
   assign s2_in_addr = cfg_set_inputreg_i ? s1_addr_q : wr_addr_i;
   assign s2_in_data = cfg_set_inputreg_i ? s1_data_q : wr_data_i[31:0];

   always_comb begin
      arm_eff  = armed_q | inject_arm_i;
      mode_eff = inject_arm_i ? inject_mode_i : mode_q;
      flip     = !arm_eff ? 32'h0 : mode_eff == 2'b01 ? 32'h1 : mode_eff == 2'b10 ? 32'h3 : 32'h0;
      c        = cfg_ecc_enable_i ? check_bits(s2_in_data) : 6'd0;
      p        = cfg_ecc_enable_i ? ^{s2_in_data, c} : 1'b0;
      // Corruption is applied after encoding so the stored check bits describe the clean word.
      word_d   = {1'b0, p, c, s2_in_data ^ flip};
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         armed_q   <= 1'b0;
         mode_q    <= 2'b00;
         s1_addr_q <= '0;
         s1_data_q <= '0;
         s2_addr_q <= '0;
         s2_word_q <= '0;
         cnt_q     <= '0;
      end else begin
         if (s1_ld) begin
            s1_addr_q <= wr_addr_i;
            s1_data_q <= wr_data_i[31:0];
         end
         s1_v_q <= s1_ld | (s1_v_q & !s2_rdy);
         if (s2_ld) begin
            s2_addr_q <= s2_in_addr;
            s2_word_q <= word_d;
         end
         s2_v_q  <= s2_ld | (s2_v_q & !ram_ready_i);
         armed_q <= s2_ld ? 1'b0 : arm_eff;
         if (inject_arm_i) mode_q <= inject_mode_i;
         if (s2_v_q & ram_ready_i) cnt_q <= cnt_q + 16'd1;
      end
   end

   assign ram_valid_o  = s2_v_q;
   assign ram_addr_o   = s2_addr_q;
   assign ram_wrdata_o = s2_word_q;
   assign wr_count_o   = cnt_q;
endmodule

// File: tb/tb_ecc_write_encoder.sv
// tb_ecc_write_encoder: directed scoreboard bench for ecc_write_encoder; a negedge monitor
// pops expected words as the SRAM side accepts them and checks holds during stalls.
module tb_ecc_write_encoder;
   typedef struct packed {
      logic [15:0] a;
      logic [39:0] w;
   } exp_t;

   logic        clk = 0, rst_n = 0, cfg_inreg = 0, cfg_ecc = 1, wr_valid = 0, inj_arm = 0, ram_ready = 1;
   logic [1:0]  inj_mode = 0;
   logic [15:0] wr_addr = 0;
   logic [31:0] wr_data = 0;
   logic        wr_ready, ram_valid;
   logic [15:0] ram_addr, wr_count;
   logic [39:0] ram_wrdata;

   exp_t        sb[$];
   int          n_asrt = 0, n_fail = 0;
   logic        tb_armed = 0;
   logic [1:0]  tb_mode = 0;
   logic        prev_stall = 0;
   logic [39:0] prev_word;
   logic [15:0] prev_addr;

   ecc_write_encoder dut (
      .clk_i(clk), .rst_n_i(rst_n), .cfg_set_inputreg_i(cfg_inreg), .cfg_ecc_enable_i(cfg_ecc),
      .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .inject_arm_i(inj_arm), .inject_mode_i(inj_mode), .ram_valid_o(ram_valid),
      .ram_ready_i(ram_ready), .ram_addr_o(ram_addr), .ram_wrdata_o(ram_wrdata), .wr_count_o(wr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Builds the full codeword, then derives each check bit from the positions it covers.
   function automatic logic [39:0] enc(input logic [31:0] d, input logic ecc, input logic [1:0] inj);
      logic [38:1] cw;
      logic [5:0]  cb;
      logic        par;
      int          j;
      cw = '0;
      j = 0;
      for (int pos = 1; pos <= 38; pos++)
         if (!(pos inside {1, 2, 4, 8, 16, 32})) begin
            cw[pos] = d[j];
            j++;
         end
      cb = '0;
      for (int k = 0; k < 6; k++)
         for (int pos = 1; pos <= 38; pos++)
            if (((pos >> k) & 1) == 1) cb[k] = cb[k] ^ cw[pos];
      if (!ecc) cb = '0;
      par = ecc ? ^{d, cb} : 1'b0;
      return {1'b0, par, cb, d ^ (inj == 2'b01 ? 32'h1 : inj == 2'b10 ? 32'h3 : 32'h0)};
   endfunction

   function automatic exp_t mk(input logic [15:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.w = enc(d, cfg_ecc, tb_armed ? tb_mode : 2'b00);
      tb_armed = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) prev_stall <= 0;
      else begin
         if (prev_stall) begin
            chk("stall_hold_data", ram_wrdata, prev_word);
            chk("stall_hold_addr", ram_addr, prev_addr);
         end
         if (ram_valid && ram_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_write", 1, 0);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_data", ram_wrdata, e.w);
               chk("sb_addr", ram_addr, e.a);
            end
         end
         prev_stall <= ram_valid && !ram_ready;
         prev_word  <= ram_wrdata;
         prev_addr  <= ram_addr;
      end
   end

   task automatic wr(input logic [15:0] a, input logic [31:0] d);
      int n = 0;
      wr_valid = 1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) chk("wr_accept_timeout", 0, 1);
      else sb.push_back(mk(a, d));
      @(posedge clk);
      #1 wr_valid = 0;
   endtask

   task automatic arm(input logic [1:0] m);
      inj_arm  = 1;
      inj_mode = m;
      @(posedge clk);
      #1 inj_arm = 0;
      tb_armed = 1;
      tb_mode  = m;
   endtask

   task automatic do_reset();
      rst_n = 0;
      sb.delete();
      tb_armed = 0;
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2;
      chk("rst_ram_valid", ram_valid, 0);
      chk("rst_wrdata", ram_wrdata, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_count", wr_count, 0);
      chk("rst_wr_ready", wr_ready, 0);
      @(posedge clk);
      #1 rst_n = 1;

      wr(16'h0010, 32'h00000001);
      chk("lat1_valid", ram_valid, 1);
      chk("lat1_word", ram_wrdata, 40'h43_00000001);
      chk("lat1_addr", ram_addr, 16'h0010);
      idle(1);
      chk("lat1_count", wr_count, 1);
      chk("lat1_drained", ram_valid, 0);

      cfg_inreg = 1;
      wr(16'h0020, 32'h00000000);
      chk("lat2_not_yet", ram_valid, 0);
      idle(1);
      chk("lat2_valid", ram_valid, 1);
      chk("lat2_word", ram_wrdata, 40'h0);
      idle(1);
      cfg_ecc = 0;
      wr(16'h0021, 32'hFFFFFFFF);
      idle(1);
      chk("noecc_word", ram_wrdata, 40'h00_FFFFFFFF);
      idle(2);
      cfg_ecc = 1;

      do_reset();
      fork
         begin
            wr(16'h0100, 32'hDEADBEEF);
            wr(16'h0101, 32'h12345678);
            wr(16'h0102, $urandom);
            wr(16'h0103, 32'h80000001);
         end
         begin
            idle(2);
            ram_ready = 0;
            repeat (3) @(posedge clk);
            #1 ram_ready = 1;
         end
      join
      idle(5);
      chk("stall_count", wr_count, 4);
      chk("stall_sb_empty", sb.size(), 0);

      cfg_inreg = 0;
      arm(2'b10);
      wr(16'h0200, 32'h00000001);
      chk("inj2_word", ram_wrdata, 40'h43_00000002);
      wr(16'h0201, 32'h00000001);
      chk("inj_after_clean", ram_wrdata, 40'h43_00000001);
      arm(2'b01);
      arm(2'b10);
      wr(16'h0202, 32'h000000F0);
      arm(2'b01);
      wr(16'h0203, 32'h000000F0);
      arm(2'b11);
      wr(16'h0204, 32'hA5A5A5A5);
      wr_valid = 1;
      wr_addr  = 16'h0205;
      wr_data  = 32'h00000005;
      inj_arm  = 1;
      inj_mode = 2'b01;
      tb_armed = 1;
      tb_mode  = 2'b01;
      sb.push_back(mk(16'h0205, 32'h00000005));
      @(posedge clk);
      #1 wr_valid = 0;
      inj_arm = 0;
      chk("inj_samecycle_d", ram_wrdata[31:0], 32'h00000004);
      wr(16'h0206, 32'h00000005);
      idle(2);

      do_reset();
      wr_valid = 1;
      for (int i = 0; i < 65535; i++) begin
         wr_addr = i[15:0];
         wr_data = i * 32'h9E3779B1;
         sb.push_back(mk(wr_addr, wr_data));
         @(posedge clk);
         #1;
      end
      wr_valid = 0;
      idle(2);
      chk("count_ffff", wr_count, 16'hFFFF);
      wr(16'hBEEF, 32'hCAFEF00D);
      idle(1);
      chk("count_wrap", wr_count, 0);

      cfg_inreg = 1;
      ram_ready = 0;
      wr(16'h0300, 32'h11111111);
      wr(16'h0301, 32'h22222222);
      chk("midrst_s2_valid", ram_valid, 1);
      rst_n = 0;
      #1;
      chk("midrst_valid_drop", ram_valid, 0);
      chk("midrst_count", wr_count, 0);
      chk("midrst_wrdata", ram_wrdata, 0);
      sb.delete();
      ram_ready = 1;
      @(posedge clk);
      #1 rst_n = 1;
      idle(4);
      chk("postrst_valid", ram_valid, 0);
      chk("postrst_count", wr_count, 0);
      chk("final_sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
